dll_rx_acknak: RTL

DLL_RX_ACKNAK -- requirements
Module: dll_rx_acknak

---
 rtl/dll_rx_acknak.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dll_rx_acknak.sv
// Receive-side data link layer: TLP sequence checking and ACK/NAK DLLP scheduling.
// Optional macro ACK_COALESCE_EN delays presentation of a pending ACK by ACK_TIMEOUT cycles.
module dll_rx_acknak #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [15:0] rx_data,
    input  logic        crc_err,
    input  logic        busy_n,
    output logic [1:0]  ack_nack,
    output logic [11:0] seq,
    output logic        tlp_good,
    output logic        tlp_drop
);
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam logic [1:0] DLLP_NONE = 2'b00;
    localparam logic [1:0] DLLP_ACK  = 2'b01;
    localparam logic [1:0] DLLP_NAK  = 2'b10;

    state_t      state, state_nxt;
    logic [11:0] rseq, rseq_nxt;
    logic        rcrc, rcrc_nxt;
    logic [11:0] next_rcv_seq, next_rcv_seq_nxt;
    logic        nak_sched, nak_sched_nxt;
    logic [1:0]  pend_type, pend_type_nxt;
    logic [11:0] pend_seq, pend_seq_nxt;
    logic        good_nxt, drop_nxt;
    logic [1:0]  req_type;
    logic [11:0] req_seq;
    logic [11:0] seq_diff;
    logic        shown;
    logic        consumed;
    logic        unused_data_hi;

    assign unused_data_hi = ^rx_data[15:12];

    assign ack_nack = shown ? pend_type : DLLP_NONE;
    assign seq      = pend_seq;
    assign consumed = busy_n && (ack_nack != DLLP_NONE);

    // Sequence check on the completed TLP, plus beat framing for the next one
    always_comb begin
        state_nxt        = state;
        rseq_nxt         = rseq;
        rcrc_nxt         = rcrc;
        next_rcv_seq_nxt = next_rcv_seq;
        nak_sched_nxt    = nak_sched;
        good_nxt         = 1'b0;
        drop_nxt         = 1'b0;
        req_type         = DLLP_NONE;
        req_seq          = next_rcv_seq - 12'd1;
        seq_diff         = next_rcv_seq - rseq;

        if (state == CHECK) begin
            state_nxt = IDLE;
            if (rcrc) begin
                drop_nxt = 1'b1;
                if (!nak_sched) begin
                    req_type      = DLLP_NAK;
                    nak_sched_nxt = 1'b1;
                end
            end else if (seq_diff == 12'd0) begin
                good_nxt         = 1'b1;
                next_rcv_seq_nxt = next_rcv_seq + 12'd1;
                nak_sched_nxt    = 1'b0;
                req_type         = DLLP_ACK;
                req_seq          = rseq;
            end else if (seq_diff <= 12'd2048) begin
                drop_nxt = 1'b1;
                req_type = DLLP_ACK;
            end else begin
                drop_nxt = 1'b1;
                if (!nak_sched) begin
                    req_type      = DLLP_NAK;
                    nak_sched_nxt = 1'b1;
                end
            end
        end

        // CHECK accepts a new sop beat like IDLE so single-beat TLPs can stream
        if (rx_valid) begin
            if (rx_sop) begin
                if (state == RECV) begin
                    drop_nxt = 1'b1;
                end
                rseq_nxt = rx_data[11:0];
                if (rx_eop) begin
                    rcrc_nxt  = crc_err;
                    state_nxt = CHECK;
                end else begin
                    state_nxt = RECV;
                end
            end else if ((state == RECV) && rx_eop) begin
                rcrc_nxt  = crc_err;
                state_nxt = CHECK;
            end
        end
    end

    // A consumed DLLP frees the slot before the new request is merged in
    always_comb begin
        pend_type_nxt = consumed ? DLLP_NONE : pend_type;
        pend_seq_nxt  = pend_seq;
        if ((req_type == DLLP_NAK) || ((req_type == DLLP_ACK) && (pend_type_nxt != DLLP_NAK))) begin
            pend_type_nxt = req_type;
            pend_seq_nxt  = req_seq;
        end
    end

`ifdef ACK_COALESCE_EN
    logic [7:0] timer, timer_nxt;

    assign shown = (pend_type == DLLP_NAK) ||
                   ((pend_type == DLLP_ACK) && (timer == 8'(ACK_TIMEOUT)));

    // Timer runs from the moment an ACK first occupies an empty slot; overwrites keep it running
    always_comb begin
        timer_nxt = timer;
        if (pend_type_nxt != DLLP_ACK) begin
            timer_nxt = 8'd0;
        end else if ((pend_type != DLLP_ACK) || consumed) begin
            timer_nxt = 8'd0;
        end else if (timer < 8'(ACK_TIMEOUT)) begin
            timer_nxt = timer + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= 8'd0;
        end else begin
            timer <= timer_nxt;
        end
    end
`else
    assign shown = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            next_rcv_seq <= 12'd0;
            nak_sched    <= 1'b0;
            pend_type    <= DLLP_NONE;
            pend_seq     <= 12'd0;
            tlp_good     <= 1'b0;
            tlp_drop     <= 1'b0;
        end else begin
            state        <= state_nxt;
            next_rcv_seq <= next_rcv_seq_nxt;
            nak_sched    <= nak_sched_nxt;
            pend_type    <= pend_type_nxt;
            pend_seq     <= pend_seq_nxt;
            tlp_good     <= good_nxt;
            tlp_drop     <= drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rseq <= rseq_nxt;
        rcrc <= rcrc_nxt;
    end
endmodule
